fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Instruction-fetch controller for the 16-byte Program_Rom.
//  - Owns the program counter and drives the ROM address.
//  - Captures the combinational ROM word into a small prefetch FIFO.
//  - Delivers {pc, instruction} to decode over a valid/ready handshake.
//  - Sits between Program_Rom and the decode stage; handles stall, redirect (branch/jump) and halt.
// PARAMETERS
//  ADDR_W    4     PC / ROM address width (byte address, word aligned)
//  DEPTH     2     prefetch FIFO entries (power of 2, >=2)
//  RESET_PC  4'h0  PC value loaded on reset
// PORTS
//  clk                 in   1       rising-edge clock
//  rst_n               in   1       async active-low reset
//  fetch_en_in         in   1       1 = fetch allowed; 0 = halt fetching (FIFO still drains)
//  Rom_addr_out        out  ADDR_W  address to Program_Rom (= PC register)
//  Rom_data_in         in   32      Program_Rom data, valid same cycle
//  inst_valid_out      out  1       FIFO head valid
//  inst_ready_in       in   1       decode accepts head
//  inst_data_out       out  32      head instruction
//  inst_pc_out         out  ADDR_W  head PC
//  redirect_valid_in   in   1       1-cycle redirect request
//  redirect_pc_in      in   ADDR_W  redirect target
//  misalign_out        out  1       1-cycle pulse: redirect target had pc[1:0]!=0
//  state_out           out  2       00 IDLE, 01 RUN, 10 STALL
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - pc=RESET_PC, FIFO empty, state IDLE.
//   - inst_valid_out=0, inst_data_out=0, inst_pc_out=0, misalign_out=0.
//  Handshake and FIFO:
//   - pop = inst_valid_out & inst_ready_in.
//   - push = fetch_en_in & ~redirect_valid_in & (count<DEPTH | pop).
//   - push writes {pc, Rom_data_in}; pc <= pc+4, modulo 2^ADDR_W (4'hC -> 4'h0).
//   - Simultaneous push+pop when full is legal; count is unchanged.
//   - Head outputs are taken from the FIFO register. inst_data_out/inst_pc_out hold while valid & ~ready.
//   - When the FIFO is empty, data/pc hold their last value.
//   - Latency: fetch_en_in high at edge N, FIFO empty -> inst_valid_out=1 after edge N, pc of that entry = old pc.
//   - Steady state with ready=1: one instruction per cycle.
//  Redirect (highest priority, any state):
//   - FIFO flushed and pc <= {redirect_pc_in[ADDR_W-1:2],2'b00} at the next edge.
//   - No push and no pop counted that cycle.
//   - inst_valid_out=0 the following cycle.
//   - misalign_out=1 for that one cycle iff redirect_pc_in[1:0]!=0.
//  FSM (evaluated on next-state values):
//   - IDLE: fetch_en_in=0.
//   - RUN: fetch_en_in=1 and FIFO not full after edge.
//   - STALL: fetch_en_in=1 and FIFO full after edge.
//   - Any state -> IDLE when fetch_en_in=0.
//   - IDLE -> RUN on fetch_en_in=1.
//   - RUN <-> STALL on full/not-full.
//   - Redirect -> RUN if fetch_en_in=1, else IDLE.
//  Halt: fetch_en_in=0 freezes pc; buffered entries remain poppable.
//  Reset mid-operation: all state cleared immediately; no partial FIFO write survives.
// TESTING
//  1 Reset, fetch_en=1, ready=1 -> (pc,data) sequence:
//    - 0/44216a93, 4/65125748, 8/ffb00193, c/156778dc.
//    - Then wraps to 0/44216a93.
//  2 ready=0 for 4 cycles -> 2 entries (pc 0,4) held stable; state=STALL; Rom_addr_out=8.
//    - Release ready -> pc 0,4,8 delivered in order, no loss or duplication.
//  3 Redirect to 4'hC while FIFO holds pc 0,4 -> FIFO flushed, valid=0 next cycle, then c/156778dc.
//  4 Redirect to 4'h6 -> misalign_out pulses once; pc aligned to 4; next delivered 4/65125748.
//  5 fetch_en=0 after 2 pushes, ready=1 -> both drain, valid drops, pc frozen, state IDLE.
//  6 rst_n low mid-stream with FIFO full -> outputs 0 immediately (async); pc=0 on release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller: PC, ROM address, prefetch FIFO, redirect and halt
module fetch_sequencer #(
    parameter int                ADDR_W   = 4,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en_in,
    output logic [ADDR_W-1:0] Rom_addr_out,
    input  logic [31:0]       Rom_data_in,
    output logic              inst_valid_out,
    input  logic              inst_ready_in,
    output logic [31:0]       inst_data_out,
    output logic [ADDR_W-1:0] inst_pc_out,
    input  logic              redirect_valid_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    output logic              misalign_out,
    output logic [1:0]        state_out
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       mem_data [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       last_data;
    logic [ADDR_W-1:0] last_pc;

    logic              handshake;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  count_next;

    assign Rom_addr_out   = pc;
    assign state_out      = state;
    assign inst_valid_out = (count != '0);

    // Head comes straight from the FIFO; when empty the last shown head is held.
    assign inst_data_out = inst_valid_out ? mem_data[rd_ptr] : last_data;
    assign inst_pc_out   = inst_valid_out ? mem_pc[rd_ptr]   : last_pc;

    // Redirect suppresses both push and pop; push may reuse a slot freed by a same-cycle pop.
    always_comb begin
        handshake  = inst_valid_out & inst_ready_in;
        pop        = handshake & ~redirect_valid_in;
        push       = fetch_en_in & ~redirect_valid_in & ((count < FULL_CNT) | handshake);
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    // PC, FIFO storage, held head copy, misalign pulse and FSM, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            last_data    <= '0;
            last_pc      <= '0;
            misalign_out <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else begin
            if (inst_valid_out) begin
                last_data <= mem_data[rd_ptr];
                last_pc   <= mem_pc[rd_ptr];
            end
            if (redirect_valid_in) begin
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                count        <= '0;
                pc           <= {redirect_pc_in[ADDR_W-1:2], 2'b00};
                misalign_out <= (redirect_pc_in[1:0] != 2'b00);
                state        <= fetch_en_in ? S_RUN : S_IDLE;
            end else begin
                misalign_out <= 1'b0;
                if (push) begin
                    mem_data[wr_ptr] <= Rom_data_in;
                    mem_pc[wr_ptr]   <= pc;
                    wr_ptr           <= wr_ptr + PTR_W'(1);
                    pc               <= pc + ADDR_W'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count_next;
                if (!fetch_en_in) begin
                    state <= S_IDLE;
                end else if (count_next == FULL_CNT) begin
                    state <= S_STALL;
                end else begin
                    state <= S_RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized and directed bench for fetch_sequencer against a queue model
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en_in = 1'b0;
    logic        inst_ready_in = 1'b0;
    logic        redirect_valid_in = 1'b0;
    logic [3:0]  redirect_pc_in = 4'h0;
    logic [3:0]  Rom_addr_out;
    logic [31:0] Rom_data_in;
    logic        inst_valid_out;
    logic [31:0] inst_data_out;
    logic [3:0]  inst_pc_out;
    logic        misalign_out;
    logic [1:0]  state_out;

    logic [31:0] rom_w [4];

    int checks = 0;
    int failures = 0;

    // reference model: queue of {pc, data}
    logic [35:0] mq [$];
    logic [3:0]  pc_m;
    logic [35:0] shown;
    logic [1:0]  st_m;
    logic        mis_m;

    fetch_sequencer #(.ADDR_W(4), .DEPTH(2), .RESET_PC(4'h0)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_en_in      (fetch_en_in),
        .Rom_addr_out     (Rom_addr_out),
        .Rom_data_in      (Rom_data_in),
        .inst_valid_out   (inst_valid_out),
        .inst_ready_in    (inst_ready_in),
        .inst_data_out    (inst_data_out),
        .inst_pc_out      (inst_pc_out),
        .redirect_valid_in(redirect_valid_in),
        .redirect_pc_in   (redirect_pc_in),
        .misalign_out     (misalign_out),
        .state_out        (state_out)
    );

    always #5 clk = ~clk;

    assign Rom_data_in = rom_w[Rom_addr_out[3:2]];

    function automatic logic e_valid();
        return mq.size() != 0;
    endfunction

    function automatic logic [35:0] e_head();
        return (mq.size() != 0) ? mq[0] : shown;
    endfunction

    task automatic model_reset();
        mq.delete();
        pc_m  = 4'h0;
        shown = 36'h0;
        st_m  = 2'b00;
        mis_m = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en_in = 1'b0;
        inst_ready_in = 1'b0;
        redirect_valid_in = 1'b0;
        redirect_pc_in = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // drive one cycle, advance the model, land on the following negedge
    task automatic cycle(input logic fen, input logic rdy, input logic rdr, input logic [3:0] rpc);
        bit pop;
        bit push;
        fetch_en_in = fen;
        inst_ready_in = rdy;
        redirect_valid_in = rdr;
        redirect_pc_in = rpc;
        if (mq.size() != 0) shown = mq[0];
        if (rdr) begin
            mq.delete();
            pc_m  = {rpc[3:2], 2'b00};
            mis_m = (rpc[1:0] != 2'b00);
            st_m  = fen ? 2'b01 : 2'b00;
        end else begin
            pop  = (mq.size() != 0) && rdy;
            push = fen && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({pc_m, rom_w[pc_m[3:2]]});
                pc_m = pc_m + 4'd4;
            end
            mis_m = 1'b0;
            st_m  = !fen ? 2'b00 : ((mq.size() == 2) ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (inst_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", inst_valid_out); end
        checks++; if (inst_data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", inst_data_out); end
        checks++; if (inst_pc_out !== 4'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", inst_pc_out); end
        checks++; if (misalign_out !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%0b exp=0", misalign_out); end
        checks++; if (state_out !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", state_out); end
        checks++; if (Rom_addr_out !== 4'h0) begin failures++; $display("FAIL reset_romaddr got=%h exp=0", Rom_addr_out); end
    endtask

    task automatic test_sequence();
        logic [3:0]  xp;
        logic [31:0] xd;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'h0);
            xp = 4'(k * 4);
            xd = rom_w[k % 4];
            checks++; if (inst_valid_out !== 1'b1) begin failures++; $display("FAIL seq_valid k=%0d got=%0b exp=1", k, inst_valid_out); end
            checks++; if ({inst_pc_out, inst_data_out} !== {xp, xd}) begin failures++; $display("FAIL seq_head k=%0d got=%h/%h exp=%h/%h", k, inst_pc_out, inst_data_out, xp, xd); end
            checks++; if (state_out !== 2'b01) begin failures++; $display("FAIL seq_state k=%0d got=%b exp=01", k, state_out); end
        end
    endtask

    task automatic test_stall();
        logic [3:0] got [$];
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 4'h0);
            checks++; if (k >= 1 && (state_out !== 2'b10 || Rom_addr_out !== 4'h8)) begin failures++; $display("FAIL stall_state k=%0d got=%b/%h exp=10/8", k, state_out, Rom_addr_out); end
            checks++; if ({inst_valid_out, inst_pc_out, inst_data_out} !== {1'b1, 4'h0, rom_w[0]}) begin failures++; $display("FAIL stall_head k=%0d got=%0b %h/%h exp=1 0/%h", k, inst_valid_out, inst_pc_out, inst_data_out, rom_w[0]); end
        end
        for (int k = 0; k < 3; k++) begin
            if (inst_valid_out) got.push_back(inst_pc_out);
            cycle(1'b1, 1'b1, 1'b0, 4'h0);
        end
        checks++; if (got.size() != 3 || got[0] !== 4'h0 || got[1] !== 4'h4 || got[2] !== 4'h8) begin failures++; $display("FAIL stall_release_order got_n=%0d exp=0,4,8", got.size()); end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 1'b1, 4'hC);
        checks++; if (inst_valid_out !== 1'b0) begin failures++; $display("FAIL redir_flush got=%0b exp=0", inst_valid_out); end
        checks++; if (Rom_addr_out !== 4'hC || state_out !== 2'b01 || misalign_out !== 1'b0) begin failures++; $display("FAIL redir_pc got=%h/%b/%0b exp=c/01/0", Rom_addr_out, state_out, misalign_out); end
        cycle(1'b1, 1'b1, 1'b0, 4'h0);
        checks++; if ({inst_valid_out, inst_pc_out, inst_data_out} !== {1'b1, 4'hC, 32'h156778dc}) begin failures++; $display("FAIL redir_target got=%0b %h/%h exp=1 c/156778dc", inst_valid_out, inst_pc_out, inst_data_out); end
    endtask

    task automatic test_misalign();
        cycle(1'b1, 1'b1, 1'b1, 4'h6);
        checks++; if (misalign_out !== 1'b1 || Rom_addr_out !== 4'h4) begin failures++; $display("FAIL misalign_pulse got=%0b/%h exp=1/4", misalign_out, Rom_addr_out); end
        cycle(1'b1, 1'b1, 1'b0, 4'h0);
        checks++; if (misalign_out !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%0b exp=0", misalign_out); end
        checks++; if ({inst_valid_out, inst_pc_out, inst_data_out} !== {1'b1, 4'h4, 32'h65125748}) begin failures++; $display("FAIL misalign_next got=%0b %h/%h exp=1 4/65125748", inst_valid_out, inst_pc_out, inst_data_out); end
    endtask

    task automatic test_halt();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 1'b0, 4'h0);
        checks++; if ({inst_valid_out, inst_pc_out, state_out, Rom_addr_out} !== {1'b1, 4'h4, 2'b00, 4'h8}) begin failures++; $display("FAIL halt_drain1 got=%0b %h %b %h exp=1 4 00 8", inst_valid_out, inst_pc_out, state_out, Rom_addr_out); end
        cycle(1'b0, 1'b1, 1'b0, 4'h0);
        cycle(1'b0, 1'b1, 1'b0, 4'h0);
        checks++; if ({inst_valid_out, state_out, Rom_addr_out} !== {1'b0, 2'b00, 4'h8}) begin failures++; $display("FAIL halt_frozen got=%0b %b %h exp=0 00 8", inst_valid_out, state_out, Rom_addr_out); end
        checks++; if ({inst_pc_out, inst_data_out} !== {4'h4, 32'h65125748}) begin failures++; $display("FAIL halt_hold got=%h/%h exp=4/65125748", inst_pc_out, inst_data_out); end
    endtask

    task automatic test_random();
        logic [35:0] eh;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) != 0),
                  ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
            eh = e_head();
            checks++; if (inst_valid_out !== e_valid()) begin failures++; $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, inst_valid_out, e_valid()); end
            checks++; if ({inst_pc_out, inst_data_out} !== eh) begin failures++; $display("FAIL rand_head n=%0d got=%h/%h exp=%h/%h", n, inst_pc_out, inst_data_out, eh[35:32], eh[31:0]); end
            checks++; if (Rom_addr_out !== pc_m) begin failures++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, Rom_addr_out, pc_m); end
            checks++; if (state_out !== st_m) begin failures++; $display("FAIL rand_state n=%0d got=%b exp=%b", n, state_out, st_m); end
            checks++; if (misalign_out !== mis_m) begin failures++; $display("FAIL rand_misalign n=%0d got=%0b exp=%0b", n, misalign_out, mis_m); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        cycle(1'b1, 1'b0, 1'b0, 4'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if ({inst_valid_out, inst_data_out, inst_pc_out, misalign_out, state_out} !== 39'h0) begin failures++; $display("FAIL async_reset got=%0b %h/%h %0b %b exp=all zero", inst_valid_out, inst_pc_out, inst_data_out, misalign_out, state_out); end
        fetch_en_in = 1'b0;
        inst_ready_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (Rom_addr_out !== 4'h0) begin failures++; $display("FAIL async_release_pc got=%h exp=0", Rom_addr_out); end
        cycle(1'b1, 1'b1, 1'b0, 4'h0);
        checks++; if ({inst_valid_out, inst_pc_out, inst_data_out} !== {1'b1, 4'h0, 32'h44216a93}) begin failures++; $display("FAIL async_restart got=%0b %h/%h exp=1 0/44216a93", inst_valid_out, inst_pc_out, inst_data_out); end
    endtask

    initial begin
        rom_w[0] = 32'h44216a93;
        rom_w[1] = 32'h65125748;
        rom_w[2] = 32'hffb00193;
        rom_w[3] = 32'h156778dc;
        model_reset();
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_misalign();
        test_halt();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
